nec_ir_transmitter: RTL and testbench
=====================================

NEC_IR_TRANSMITTER -- requirements
Module: nec_ir_transmitter

Interface
REQ-001 Parameter CLOCK_HZ, default 50_000_000, clkIN frequency in Hz.
REQ-002 Parameter CARRIER_HZ, default 38_000, IR carrier frequency in Hz.
REQ-003 clkIN  input  1  system clock, all logic on the rising edge.
REQ-004 nResetIN  input  1  reset, asynchronous, active-low.
REQ-005 startIN  input  1  level request to send a full data frame, sampled in IDLE only.
REQ-006 repeatIN  input  1  level request to send a repeat code, sampled in IDLE only.
REQ-007 dataIN  input  32  frame payload, transmitted LSB first.
REQ-008 busyOUT  output  1  high from frame acceptance until end of the frame period.
REQ-009 doneOUT  output  1  single-cycle pulse at the end of the frame period.
REQ-010 envelopeOUT  output  1  unmodulated frame, 1 = mark, 0 = space.
REQ-011 irOUT  output  1  envelopeOUT AND carrier, for the IR LED driver.

Function
REQ-012 Time unit T = 562.5 us, implemented as UNIT_CYCLES = CLOCK_HZ/1778 clkIN cycles (integer division), from a unit counter that restarts on frame acceptance.
REQ-013 Carrier half-period = CLOCK_HZ/(2*CARRIER_HZ) cycles; carrier restarts high on the first cycle of every mark and gives 50% duty.
REQ-014 States: IDLE, LEAD_MARK, LEAD_SPACE, REPEAT_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
REQ-015 IDLE: if startIN = 1 the block latches dataIN, sets busyOUT and goes to LEAD_MARK; otherwise, if repeatIN = 1, it goes to LEAD_MARK with a repeat flag set.
REQ-016 startIN has priority when startIN and repeatIN are both high in the same cycle.
REQ-017 Latency: request sampled on edge N means envelopeOUT = 1 and busyOUT = 1 after edge N+1.
REQ-018 LEAD_MARK lasts 16 T.
- Data frame: next state is LEAD_SPACE (8 T).
- Repeat code: next state is REPEAT_SPACE (4 T).
REQ-019 Data frame timing per bit: BIT_MARK 1 T, then BIT_SPACE of 1 T for bit 0 or 3 T for bit 1.
- The bit index is 0..31, LSB first.
- After bit 31 the next state is STOP_MARK.
REQ-020 REPEAT_SPACE goes to STOP_MARK.
REQ-021 STOP_MARK lasts 1 T, then the next state is GAP.
REQ-022 Frame period is fixed at 192 T (108 ms), measured from the first LEAD_MARK cycle.
- GAP holds envelopeOUT = 0 for the remaining units: 192 − active units.
REQ-023 On the last GAP cycle doneOUT = 1 for exactly one cycle; on the next edge busyOUT = 0 and the state is IDLE.
REQ-024 startIN and repeatIN are ignored while busyOUT = 1; there is no queuing.
- A request held high across the IDLE return starts the next frame immediately.
- Back-to-back frames are therefore exactly 192 T apart.
REQ-025 dataIN changes after acceptance have no effect on the frame in progress.
REQ-026 envelopeOUT = 1 only in LEAD_MARK, BIT_MARK and STOP_MARK.
- irOUT = 0 whenever envelopeOUT = 0.
- Both outputs are registered and glitch-free.

Reset
REQ-027 While nResetIN = 0 the following hold, independent of clkIN:
- State is IDLE; all counters are cleared.
- busyOUT = 0, doneOUT = 0, envelopeOUT = 0, irOUT = 0; the latched data is 0.
REQ-028 Reset asserted mid-frame aborts the frame without a doneOUT pulse.
- After release the block waits in IDLE for a new request.

Verification (CLOCK_HZ = 1_778_000 → UNIT_CYCLES = 1000; CARRIER_HZ = 38_000 → half-period 23)
REQ-029 Data frame, dataIN = 0x00FF00FF, startIN pulsed for 1 cycle:
- envelopeOUT timing: mark 16000 cycles, space 8000 cycles, then 8 bits of (1000 mark / 3000 space), 8 bits of (1000 mark / 1000 space), repeated once more, then 1000 stop mark.
- Active time 121 T, gap 71 T.
- doneOUT is a single pulse at cycle 192000 after acceptance.
REQ-030 Repeat code, repeatIN pulsed: mark 16000, space 4000, mark 1000 cycles, then 171000 cycles of gap; busyOUT is high for 192000 cycles.
REQ-031 Priority and blocking:
- startIN and repeatIN high together: a data frame is sent.
- startIN re-asserted at T = 50: ignored; no second frame and one doneOUT pulse.
REQ-032 Carrier: during every mark, irOUT toggles every 23 cycles and starts high on the mark's first cycle; irOUT = 0 throughout every space.
REQ-033 Reset: nResetIN pulsed low during BIT_SPACE of bit 10:
- All outputs are 0 asynchronously, with no doneOUT pulse.
- A subsequent startIN produces a complete, correct frame.
REQ-034 Continuous startIN held high for 3 frames: lead-mark rising edges are exactly 192000 cycles apart, with 3 doneOUT pulses.

Source files
------------

// File: rtl/nec_ir_if.sv
// Request/status bundle between a frame source and the NEC IR transmitter.
interface nec_ir_if;
    logic        startIN;
    logic        repeatIN;
    logic [31:0] dataIN;
    logic        busyOUT;
    logic        doneOUT;
    logic        envelopeOUT;
    logic        irOUT;

    modport master (
        output startIN, repeatIN, dataIN,
        input  busyOUT, doneOUT, envelopeOUT, irOUT
    );

    modport slave (
        input  startIN, repeatIN, dataIN,
        output busyOUT, doneOUT, envelopeOUT, irOUT
    );
endinterface

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: sends 32-bit data frames or repeat codes in a fixed
// 192-unit frame period, with a carrier-modulated LED output.
module nec_ir_transmitter #(
    parameter int unsigned CLOCK_HZ   = 50_000_000,
    parameter int unsigned CARRIER_HZ = 38_000
) (
    input  logic     clkIN,
    input  logic     nResetIN,
    nec_ir_if.slave  bus
);
    localparam int unsigned UNIT_CYCLES = CLOCK_HZ / 1778;
    localparam int unsigned HALF_CYCLES = CLOCK_HZ / (2 * CARRIER_HZ);
    localparam int unsigned FRAME_UNITS = 192;
    localparam int unsigned UNIT_W      = $clog2(UNIT_CYCLES + 1);
    localparam int unsigned HALF_W      = $clog2(HALF_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_REPEAT_SPACE,
        S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
    } state_t;

    state_t              r_state;
    logic [UNIT_W-1:0]   r_unit_cnt;
    logic [3:0]          r_units_left;
    logic [7:0]          r_frame_units;
    logic [4:0]          r_bit;
    logic                r_repeat;
    logic [31:0]         r_data;
    logic                r_start_q;
    logic                r_repeat_q;
    logic [31:0]         r_data_q;
    logic [HALF_W-1:0]   r_car_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_env;
    logic                r_ir;

    logic w_unit_end;
    logic w_seg_end;
    logic w_frame_end;
    logic w_car_end;
    logic w_accept;
    logic w_done_next;

    assign w_unit_end  = (r_unit_cnt == UNIT_W'(UNIT_CYCLES - 1));
    assign w_seg_end   = w_unit_end && (r_units_left == 4'd0);
    assign w_frame_end = w_unit_end && (r_frame_units == 8'(FRAME_UNITS - 1));
    assign w_car_end   = (r_car_cnt == HALF_W'(HALF_CYCLES - 1));
    // A request may start a frame from IDLE or on the final GAP cycle, so
    // back-to-back frames keep the exact frame period.
    assign w_accept    = (r_start_q || r_repeat_q) &&
                         ((r_state == S_IDLE) || ((r_state == S_GAP) && w_frame_end));
    assign w_done_next = (r_state == S_GAP) &&
                         (r_frame_units == 8'(FRAME_UNITS - 1)) &&
                         (r_unit_cnt == UNIT_W'(UNIT_CYCLES - 2));

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_state       <= S_IDLE;
            r_unit_cnt    <= '0;
            r_units_left  <= 4'd0;
            r_frame_units <= 8'd0;
            r_bit         <= 5'd0;
            r_repeat      <= 1'b0;
            r_data        <= 32'd0;
            r_start_q     <= 1'b0;
            r_repeat_q    <= 1'b0;
            r_data_q      <= 32'd0;
            r_car_cnt     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_env         <= 1'b0;
            r_ir          <= 1'b0;
        end else begin
            r_start_q  <= bus.startIN;
            r_repeat_q <= bus.repeatIN;
            r_data_q   <= bus.dataIN;
            r_done     <= w_done_next;

            if (r_env) begin
                if (w_car_end) begin
                    r_car_cnt <= '0;
                    r_ir      <= ~r_ir;
                end else begin
                    r_car_cnt <= r_car_cnt + HALF_W'(1);
                end
            end

            if (r_state != S_IDLE) begin
                r_unit_cnt <= w_unit_end ? '0 : r_unit_cnt + UNIT_W'(1);
                if (w_unit_end) begin
                    r_frame_units <= r_frame_units + 8'd1;
                    r_units_left  <= r_units_left - 4'd1;
                end
            end

            // Segment transitions; a mark always restarts the carrier high.
            case (r_state)
                S_LEAD_MARK: if (w_seg_end) begin
                    r_state      <= r_repeat ? S_REPEAT_SPACE : S_LEAD_SPACE;
                    r_units_left <= r_repeat ? 4'd3 : 4'd7;
                    r_env        <= 1'b0;
                    r_ir         <= 1'b0;
                end
                S_LEAD_SPACE, S_REPEAT_SPACE: if (w_seg_end) begin
                    r_state      <= (r_state == S_LEAD_SPACE) ? S_BIT_MARK : S_STOP_MARK;
                    r_units_left <= 4'd0;
                    r_env        <= 1'b1;
                    r_ir         <= 1'b1;
                    r_car_cnt    <= '0;
                end
                S_BIT_MARK: if (w_seg_end) begin
                    r_state      <= S_BIT_SPACE;
                    r_units_left <= r_data[r_bit] ? 4'd2 : 4'd0;
                    r_env        <= 1'b0;
                    r_ir         <= 1'b0;
                end
                S_BIT_SPACE: if (w_seg_end) begin
                    r_state      <= (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    r_bit        <= r_bit + 5'd1;
                    r_units_left <= 4'd0;
                    r_env        <= 1'b1;
                    r_ir         <= 1'b1;
                    r_car_cnt    <= '0;
                end
                S_STOP_MARK: if (w_seg_end) begin
                    r_state <= S_GAP;
                    r_env   <= 1'b0;
                    r_ir    <= 1'b0;
                end
                S_GAP: if (w_frame_end) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase

            if (w_accept) begin
                r_state       <= S_LEAD_MARK;
                r_repeat      <= !r_start_q;
                if (r_start_q) r_data <= r_data_q;
                r_busy        <= 1'b1;
                r_env         <= 1'b1;
                r_ir          <= 1'b1;
                r_car_cnt     <= '0;
                r_unit_cnt    <= '0;
                r_units_left  <= 4'd15;
                r_frame_units <= 8'd0;
                r_bit         <= 5'd0;
            end
        end
    end

    assign bus.busyOUT     = r_busy;
    assign bus.doneOUT     = r_done;
    assign bus.envelopeOUT = r_env;
    assign bus.irOUT       = r_ir;
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Randomized bench for nec_ir_transmitter with a segment-list frame model,
// run at a scaled clock (10 cycles per unit, carrier half-period 3).
module tb_nec_ir_transmitter;
    localparam int unsigned CLK_HZ = 17_780;
    localparam int unsigned CAR_HZ = 2_963;
    localparam int T     = CLK_HZ / 1778;
    localparam int HALF  = CLK_HZ / (2 * CAR_HZ);
    localparam int FRAME = 192 * T;

    logic clkIN    = 1'b0;
    logic nResetIN = 1'b1;
    nec_ir_if bus();

    nec_ir_transmitter #(.CLOCK_HZ(CLK_HZ), .CARRIER_HZ(CAR_HZ)) dut (
        .clkIN(clkIN), .nResetIN(nResetIN), .bus(bus)
    );

    always #5 clkIN = ~clkIN;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame model: a list of (length, mark) segments built from the frame rules.
    int   seg_len[$];
    bit   seg_mark[$];
    int   m_active_units;
    bit   m_active;
    int   m_c;
    bit   p_s, p_r;
    logic [31:0] p_d;

    function automatic void build(bit data_frame, logic [31:0] d);
        int sum;
        seg_len.delete(); seg_mark.delete();
        seg_len.push_back(16 * T); seg_mark.push_back(1'b1);
        if (data_frame) begin
            seg_len.push_back(8 * T); seg_mark.push_back(1'b0);
            for (int i = 0; i < 32; i++) begin
                seg_len.push_back(T); seg_mark.push_back(1'b1);
                seg_len.push_back(d[i] ? 3 * T : T); seg_mark.push_back(1'b0);
            end
        end else begin
            seg_len.push_back(4 * T); seg_mark.push_back(1'b0);
        end
        seg_len.push_back(T); seg_mark.push_back(1'b1);
        sum = 0;
        foreach (seg_len[i]) sum += seg_len[i];
        m_active_units = sum / T;
        seg_len.push_back(FRAME - sum); seg_mark.push_back(1'b0);
    endfunction

    function automatic int seg_at(int c);
        int base = 0;
        foreach (seg_len[i]) begin
            if (c < base + seg_len[i]) return i;
            base += seg_len[i];
        end
        return -1;
    endfunction

    function automatic logic [3:0] expected();
        int base = 0;
        bit env = 1'b0, ir = 1'b0;
        if (!m_active) return 4'b0000;
        foreach (seg_len[i]) begin
            if (m_c < base + seg_len[i]) begin
                env = seg_mark[i];
                ir  = seg_mark[i] && (((m_c - base) / HALF) % 2 == 0);
                break;
            end
            base += seg_len[i];
        end
        return {1'b1, (m_c == FRAME - 1), env, ir};
    endfunction

    always @(posedge clkIN) cyc++;

    // Requests are sampled every edge and acted on one edge later, only when idle.
    always @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            m_active = 1'b0; m_c = 0; p_s = 1'b0; p_r = 1'b0; p_d = 32'd0;
        end else begin
            if (m_active) begin
                m_c++;
                if (m_c == FRAME) m_active = 1'b0;
            end
            if (!m_active && (p_s || p_r)) begin
                build(p_s, p_d);
                m_active = 1'b1;
                m_c = 0;
            end
            p_s = bus.startIN; p_r = bus.repeatIN; p_d = bus.dataIN;
        end
    end

    always @(negedge clkIN) begin
        if (nResetIN && chk_en)
            check("outputs{busy,done,env,ir}",
                  {bus.busyOUT, bus.doneOUT, bus.envelopeOUT, bus.irOUT}, expected());
    end

    // Waveform measurements used by the literal expectations.
    bit prev_env = 0, prev_ir = 0;
    int mark_start, ir_rise, done_cnt, done_cyc, busy_cnt, accept_cyc;
    int rise_q[$], marks_q[$], lead_q[$], ir_runs[$];

    always @(negedge clkIN) begin
        if (bus.envelopeOUT && !prev_env) begin rise_q.push_back(cyc); mark_start = cyc; end
        if (!bus.envelopeOUT && prev_env) begin
            marks_q.push_back(cyc - mark_start);
            if (cyc - mark_start == 16 * T) lead_q.push_back(mark_start);
        end
        if (bus.irOUT && !prev_ir) ir_rise = cyc;
        if (!bus.irOUT && prev_ir && bus.envelopeOUT) ir_runs.push_back(cyc - ir_rise);
        if (bus.doneOUT) begin done_cnt++; done_cyc = cyc; end
        if (bus.busyOUT) busy_cnt++;
        prev_env = bus.envelopeOUT;
        prev_ir  = bus.irOUT;
    end

    task automatic clear_meas();
        rise_q.delete(); marks_q.delete(); lead_q.delete(); ir_runs.delete();
        done_cnt = 0; busy_cnt = 0;
    endtask

    task automatic pulse(bit s, bit r, logic [31:0] d);
        @(negedge clkIN);
        bus.startIN = s; bus.repeatIN = r; bus.dataIN = d;
        @(negedge clkIN);
        accept_cyc = cyc;
        bus.startIN = 1'b0; bus.repeatIN = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        int n = 0;
        repeat (2) @(negedge clkIN);
        while ((m_active || bus.busyOUT) && n < maxc) begin
            @(negedge clkIN);
            n++;
        end
        check("wait_idle_busy_at_timeout", longint'(m_active || bus.busyOUT), 0);
    endtask

    initial begin
        #(900_000 * 10);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit s, r;
        int n;
        bus.startIN = 1'b0; bus.repeatIN = 1'b0; bus.dataIN = 32'd0;
        #2 nResetIN = 1'b0;
        #10 check("reset_outputs", {bus.busyOUT, bus.doneOUT, bus.envelopeOUT, bus.irOUT}, 0);
        repeat (2) @(negedge clkIN);
        nResetIN = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clkIN);

        // Reference data frame; dataIN changes right after acceptance.
        clear_meas();
        pulse(1'b1, 1'b0, 32'h00FF_00FF);
        bus.dataIN = $urandom;
        wait_idle(FRAME + 20);
        check("data_done_latency", done_cyc - accept_cyc, 1920);
        check("data_done_count", done_cnt, 1);
        check("data_active_units", m_active_units, 121);
        check("data_mark_count", marks_q.size(), 34);
        check("data_lead_mark_len", marks_q.size() > 0 ? marks_q[0] : -1, 160);
        check("data_lead_to_bit0", rise_q.size() > 1 ? rise_q[1] - rise_q[0] : -1, 240);
        check("data_bit0_period", rise_q.size() > 2 ? rise_q[2] - rise_q[1] : -1, 40);
        check("carrier_first_half", ir_runs.size() > 0 ? ir_runs[0] : -1, 3);
        check("data_busy_cycles", busy_cnt, 1920);

        // Repeat code.
        clear_meas();
        pulse(1'b0, 1'b1, $urandom);
        wait_idle(FRAME + 20);
        check("rep_busy_cycles", busy_cnt, 1920);
        check("rep_mark_count", marks_q.size(), 2);
        check("rep_stop_mark_len", marks_q.size() > 1 ? marks_q[1] : -1, 10);
        check("rep_lead_to_stop", rise_q.size() > 1 ? rise_q[1] - rise_q[0] : -1, 200);

        // Start and repeat together: a data frame.
        clear_meas();
        pulse(1'b1, 1'b1, 32'hA5A5_0F0F);
        wait_idle(FRAME + 20);
        check("prio_mark_count", marks_q.size(), 34);
        check("prio_done_count", done_cnt, 1);

        // Requests during a frame are ignored.
        clear_meas();
        pulse(1'b1, 1'b0, 32'h1234_5678);
        repeat (50 * T - 2) @(negedge clkIN);
        pulse(1'b1, 1'b0, 32'hFFFF_FFFF);
        pulse(1'b0, 1'b1, 32'd0);
        wait_idle(FRAME + 20);
        check("block_done_count", done_cnt, 1);
        check("block_mark_count", marks_q.size(), 34);

        // Random frames with random in-frame requests.
        for (int it = 0; it < 5; it++) begin
            s = 1'($urandom_range(0, 1));
            r = s ? 1'($urandom_range(0, 1)) : 1'b1;
            repeat ($urandom_range(1, 20)) @(negedge clkIN);
            pulse(s, r, $urandom);
            repeat ($urandom_range(10, 1500)) @(negedge clkIN);
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            wait_idle(3 * FRAME);
        end

        // Reset during the space of bit 10 (bit 10 = 1, long space).
        clear_meas();
        pulse(1'b1, 1'b0, 32'h0000_0400);
        n = 0;
        while (!(m_active && seg_at(m_c) == 23) && n < FRAME) begin
            @(negedge clkIN);
            n++;
        end
        check("reached_bit10_space", seg_at(m_c), 23);
        repeat (3) @(negedge clkIN);
        #2 nResetIN = 1'b0;
        #1 check("midframe_reset_outputs",
                 {bus.busyOUT, bus.doneOUT, bus.envelopeOUT, bus.irOUT}, 0);
        repeat (2) @(negedge clkIN);
        nResetIN = 1'b1;
        repeat (10) @(negedge clkIN);
        check("midframe_reset_no_done", done_cnt, 0);
        check("midframe_reset_idle_busy", bus.busyOUT, 0);
        clear_meas();
        pulse(1'b1, 1'b0, 32'hC3C3_5AA5);
        wait_idle(FRAME + 20);
        check("post_reset_done_count", done_cnt, 1);
        check("post_reset_mark_count", marks_q.size(), 34);

        // startIN held for three frames.
        clear_meas();
        @(negedge clkIN);
        bus.startIN = 1'b1; bus.dataIN = $urandom;
        n = 0;
        while (done_cnt < 2 && n < 3 * FRAME) begin
            @(negedge clkIN);
            n++;
        end
        repeat (10) @(negedge clkIN);
        bus.startIN = 1'b0;
        wait_idle(2 * FRAME);
        check("cont_done_count", done_cnt, 3);
        check("cont_lead_count", lead_q.size(), 3);
        check("cont_period_1", lead_q.size() > 1 ? lead_q[1] - lead_q[0] : -1, 1920);
        check("cont_period_2", lead_q.size() > 2 ? lead_q[2] - lead_q[1] : -1, 1920);

        repeat (5) @(negedge clkIN);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
